// File: rtl/joy_db15_resp_pkg.sv
// Shared types and constants for the DB15 joystick responder.
// The optional input filter is enabled with JOY_DB15_RESP_FILTER_EN.
package joy_db15_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOADED = 2'd1,
      SHIFT  = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int DB15_BITS_PER_PLAYER = 16;

   localparam int DB15_BIT_R = 0;
   localparam int DB15_BIT_L = 1;
   localparam int DB15_BIT_D = 2;
   localparam int DB15_BIT_U = 3;

   // One frame carries both players back to back.
   function automatic int db15_frame_len(input int nbits);
      return 2 * nbits;
   endfunction

   function automatic logic [DB15_BITS_PER_PLAYER-1:0] db15_dir_mask();
      logic [DB15_BITS_PER_PLAYER-1:0] m;
      m = '0;
      m[DB15_BIT_R] = 1'b1;
      m[DB15_BIT_L] = 1'b1;
      m[DB15_BIT_D] = 1'b1;
      m[DB15_BIT_U] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/joy_db15_resp_sync_edge.sv
// Two-flop synchroniser plus edge detector for one asynchronous pin.
// With JOY_DB15_RESP_FILTER_EN the level must hold FILT_LEN samples before it is accepted.
module joy_sync_edge #(
   parameter int   FILT_LEN = 3,
   parameter logic RST_VAL  = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_async,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_level;
   logic w_level_nxt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

`ifdef JOY_DB15_RESP_FILTER_EN
   // Window of the last FILT_LEN synchronised samples, newest in bit 0.
   logic [FILT_LEN-2:0] r_hist;
   logic [FILT_LEN-1:0] w_win;

   assign w_win = {r_hist, r_sync};

   always_comb begin
      w_level_nxt = r_level;
      if (&w_win) begin
         w_level_nxt = 1'b1;
      end else if (~|w_win) begin
         w_level_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hist  <= {(FILT_LEN-1){RST_VAL}};
         r_level <= RST_VAL;
      end else begin
         r_hist  <= w_win[FILT_LEN-2:0];
         r_level <= w_level_nxt;
      end
   end
`else
   logic w_unused_filt;
   assign w_unused_filt = (FILT_LEN > 0);

   assign w_level_nxt = r_sync;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_level <= RST_VAL;
      end else begin
         r_level <= r_sync;
      end
   end
`endif

   // Edges compare the accepted level against the previous accepted level.
   assign o_level = w_level_nxt;
   assign o_rise  = w_level_nxt & ~r_level;
   assign o_fall  = ~w_level_nxt & r_level;

endmodule

// File: rtl/joy_db15_resp.sv
// Peripheral-side DB15 joystick responder: parallel load, serial shift-out, active-low data.
// Defining JOY_DB15_RESP_FILTER_EN adds a glitch filter on joy_clk and joy_load.
module joy_db15_resp
   import joy_db15_pkg::*;
#(
   parameter int NBITS    = DB15_BITS_PER_PLAYER,
   parameter int TIMEOUT  = 4096,
   parameter int FILT_LEN = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             joy_clk,
   input  logic             joy_load,
   input  logic [NBITS-1:0] joystick1,
   input  logic [NBITS-1:0] joystick2,
   output logic             joy_data,
   output logic             frame_done,
   output logic [7:0]       frame_count,
   output logic             timeout,
   output logic             busy,
   output state_t           o_dbg_state
);

   localparam int FRAME_LEN = db15_frame_len(NBITS);
   localparam int CNT_W     = $clog2(FRAME_LEN);
   localparam int WD_W      = $clog2(TIMEOUT + 1);

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

   logic w_clk_lvl;
   logic w_clk_rise;
   logic w_clk_fall;
   logic w_load_lvl;
   logic w_load_rise;
   logic w_load_fall;
   logic w_unused_edges;

   logic [FRAME_LEN-1:0] w_load_val;

   state_t               r_state;
   logic [FRAME_LEN-1:0] r_shift;
   logic [CNT_W-1:0]     r_bit_cnt;
   logic [WD_W-1:0]      r_wd;
   logic [7:0]           r_frame_count;
   logic                 r_frame_done;
   logic                 r_timeout;

   joy_sync_edge #(
      .FILT_LEN (FILT_LEN),
      .RST_VAL  (1'b0)
   ) u_sync_clk (
      .clk     (clk),
      .reset_n (reset_n),
      .i_async (joy_clk),
      .o_level (w_clk_lvl),
      .o_rise  (w_clk_rise),
      .o_fall  (w_clk_fall)
   );

   // Load idles high, so its synchroniser resets high to avoid a phantom load.
   joy_sync_edge #(
      .FILT_LEN (FILT_LEN),
      .RST_VAL  (1'b1)
   ) u_sync_load (
      .clk     (clk),
      .reset_n (reset_n),
      .i_async (joy_load),
      .o_level (w_load_lvl),
      .o_rise  (w_load_rise),
      .o_fall  (w_load_fall)
   );

   assign w_unused_edges = ^{w_clk_lvl, w_clk_fall, w_load_rise, w_load_fall};

   // Bit 0 leaves first, so player 1 bit 0 is the head of the stream.
   assign w_load_val = ~{joystick2, joystick1};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= IDLE;
         r_shift       <= '1;
         r_bit_cnt     <= '0;
         r_wd          <= '0;
         r_frame_count <= '0;
         r_frame_done  <= 1'b0;
         r_timeout     <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         r_timeout    <= 1'b0;

         case (r_state)
            IDLE: begin
               if (!w_load_lvl) begin
                  r_shift   <= w_load_val;
                  r_bit_cnt <= '0;
                  r_wd      <= '0;
                  r_state   <= LOADED;
               end
            end

            LOADED: begin
               r_wd <= '0;
               if (!w_load_lvl) begin
                  r_shift   <= w_load_val;
                  r_bit_cnt <= '0;
               end else begin
                  r_state <= SHIFT;
               end
            end

            SHIFT: begin
               // A new load beats a coincident clock edge.
               if (!w_load_lvl) begin
                  r_shift   <= w_load_val;
                  r_bit_cnt <= '0;
                  r_wd      <= '0;
                  r_state   <= LOADED;
               end else if (w_clk_rise) begin
                  r_shift <= {1'b1, r_shift[FRAME_LEN-1:1]};
                  r_wd    <= '0;
                  if (r_bit_cnt == LAST_BIT) begin
                     r_frame_done  <= 1'b1;
                     r_frame_count <= r_frame_count + 8'd1;
                     r_state       <= DONE;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end else if (r_wd == WD_LAST) begin
                  r_timeout <= 1'b1;
                  r_shift   <= '1;
                  r_wd      <= '0;
                  r_state   <= IDLE;
               end else begin
                  r_wd <= r_wd + 1'b1;
               end
            end

            DONE: begin
               if (!w_load_lvl) begin
                  r_shift   <= w_load_val;
                  r_bit_cnt <= '0;
                  r_wd      <= '0;
                  r_state   <= LOADED;
               end
            end

            default: begin
               r_state <= IDLE;
               r_shift <= '1;
            end
         endcase
      end
   end

   // After a full frame the serial-in ones have filled the register, so data idles high.
   assign joy_data    = r_shift[0];
   assign frame_done  = r_frame_done;
   assign frame_count = r_frame_count;
   assign timeout     = r_timeout;
   assign busy        = (r_state == LOADED) || (r_state == SHIFT);
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_joy_db15_resp.sv
// Bench for joy_db15_resp: random frames against a word-level model of the serial stream.
// Build with JOY_DB15_RESP_FILTER_EN to also exercise the glitch filter.
module tb_joy_db15_resp;
  import joy_db15_pkg::*;

  localparam int NB = 16;
  localparam int FL = 2 * NB;
`ifdef JOY_DB15_RESP_FILTER_EN
  localparam int HMIN = 3;
`else
  localparam int HMIN = 2;
`endif

  logic          clk;
  logic          reset_n;
  logic          joy_clk;
  logic          joy_load;
  logic [NB-1:0] joystick1;
  logic [NB-1:0] joystick2;
  logic          joy_data;
  logic          frame_done;
  logic [7:0]    frame_count;
  logic          timeout;
  logic          busy;
  state_t        dbg_state;

  int n_checks;
  int n_fail;
  int done_cnt;
  int to_cnt;
  int exp_count;
  int bit_idx;
  logic [0:0] exp_q[$];

  joy_db15_resp dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .joy_clk     (joy_clk),
    .joy_load    (joy_load),
    .joystick1   (joystick1),
    .joystick2   (joystick2),
    .joy_data    (joy_data),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .timeout     (timeout),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL sim_watchdog time limit reached");
    $fatal(1, "simulation time limit");
  end

  always @(negedge clk) begin
    if (frame_done) done_cnt <= done_cnt + 1;
    if (timeout)    to_cnt   <= to_cnt + 1;
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Reader sees bit k of {p2,p1} inverted; anything past the frame reads released.
  function automatic logic model_bit(input logic [NB-1:0] p1, input logic [NB-1:0] p2, input int k);
    logic [FL-1:0] w;
    w = {p2, p1};
    if (k < FL) return ~w[k];
    return 1'b1;
  endfunction

  task automatic model_load(input logic [NB-1:0] p1, input logic [NB-1:0] p2);
    exp_q.delete();
    for (int k = 0; k < FL + 16; k++) exp_q.push_back(model_bit(p1, p2, k));
    bit_idx = 0;
  endtask

  function automatic logic next_exp();
    if (exp_q.size() == 0) return 1'b1;
    return exp_q.pop_front();
  endfunction

  // ---------------- drivers ----------------
  task automatic do_load(input logic [NB-1:0] p1, input logic [NB-1:0] p2);
    @(posedge clk); #1;
    joystick1 = p1;
    joystick2 = p2;
    joy_load  = 1'b0;
    repeat (6) @(posedge clk);
    #1 joy_load = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    model_load(p1, p2);
    // Inputs wander mid-frame; only the loaded snapshot may appear.
    joystick1 = NB'($urandom);
    joystick2 = NB'($urandom);
    check_eq("busy_after_load", busy, 1);
  endtask

  task automatic pulse_rise(input int h);
    @(negedge clk);
    check_eq($sformatf("bit%0d", bit_idx), joy_data, next_exp());
    bit_idx++;
    @(posedge clk); #1 joy_clk = 1'b1;
    repeat (h) @(posedge clk);
    #1 joy_clk = 1'b0;
    repeat (h - 1) @(posedge clk);
  endtask

  task automatic run_frame(input logic [NB-1:0] p1, input logic [NB-1:0] p2, input int nr, input int h);
    int d0;
    d0 = done_cnt;
    do_load(p1, p2);
    repeat (nr) pulse_rise(h);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_eq("tail_bit", joy_data, next_exp());
    if (nr >= FL) begin
      exp_count++;
      check_eq("state_done", dbg_state, DONE);
      check_eq("busy_done", busy, 0);
    end
    check_eq("frame_done_cnt", done_cnt - d0, (nr >= FL) ? 1 : 0);
    check_eq("frame_count", frame_count, exp_count % 256);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    int t0;
    int c;
    logic [NB-1:0] c1;
    logic [NB-1:0] c2;

    reset_n   = 1'b0;
    joy_clk   = 1'b0;
    joy_load  = 1'b1;
    joystick1 = '0;
    joystick2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_joy_data", joy_data, 1);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_frame_count", frame_count, 0);
    check_eq("rst_timeout", timeout, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_state", dbg_state, IDLE);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (4) @(posedge clk);

    // Basic frame, then over-clocked frame.
    run_frame(16'h0011, 16'h8002, 32, 4);
    run_frame(16'h0011, 16'h8002, 40, 4);
    run_frame(db15_dir_mask(), ~db15_dir_mask(), 32, 3);

    // Random words, random frame lengths (short frames abort via the next load).
    for (int i = 0; i < 12; i++)
      run_frame(NB'($urandom), NB'($urandom), $urandom_range(1, 40), $urandom_range(HMIN, 6));

    // Restart after 10 bits must not produce frame_done or timeout.
    t0 = to_cnt;
    run_frame(NB'($urandom), NB'($urandom), 10, 3);
    run_frame(NB'($urandom), NB'($urandom), 32, 3);
    check_eq("restart_no_timeout", to_cnt - t0, 0);

    // Coincident load fall and clock rise: stream restarts at the new word.
    do_load(NB'($urandom), NB'($urandom));
    repeat (6) pulse_rise(4);
    c1 = NB'($urandom);
    c2 = NB'($urandom);
    d0 = done_cnt;
    @(posedge clk); #1;
    joystick1 = c1;
    joystick2 = c2;
    joy_load  = 1'b0;
    joy_clk   = 1'b1;
    repeat (6) @(posedge clk);
    #1 joy_clk = 1'b0;
    repeat (2) @(posedge clk);
    #1 joy_load = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    model_load(c1, c2);
    repeat (FL) pulse_rise(4);
    repeat (6) @(posedge clk);
    @(negedge clk);
    exp_count++;
    check_eq("coinc_done", done_cnt - d0, 1);
    check_eq("coinc_count", frame_count, exp_count % 256);

    // Watchdog: 5 bits then silence.
    t0 = to_cnt;
    d0 = done_cnt;
    do_load(NB'($urandom), NB'($urandom));
    repeat (5) pulse_rise(4);
    c = 0;
    while (to_cnt == t0 && c < 5000) begin
      @(posedge clk);
      c++;
    end
    check_eq("timeout_in_window", (c >= 4050 && c <= 4150) ? 1 : 0, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("timeout_pulses", to_cnt - t0, 1);
    check_eq("timeout_joy_data", joy_data, 1);
    check_eq("timeout_busy", busy, 0);
    check_eq("timeout_state", dbg_state, IDLE);
    check_eq("timeout_count", frame_count, exp_count % 256);
    check_eq("timeout_no_done", done_cnt - d0, 0);

`ifdef JOY_DB15_RESP_FILTER_EN
    // A 2-sample clock glitch is rejected; a 3-sample pulse shifts one bit.
    do_load(NB'($urandom), NB'($urandom));
    @(posedge clk); #1 joy_clk = 1'b1;
    repeat (2) @(posedge clk);
    #1 joy_clk = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_eq("filt_glitch_bit0", joy_data, exp_q[0]);
    pulse_rise(3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_eq("filt_pulse_bit1", joy_data, exp_q[0]);
`endif

    // Asynchronous reset in the middle of a frame.
    do_load(NB'($urandom), NB'($urandom));
    repeat (7) pulse_rise(3);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("areset_joy_data", joy_data, 1);
    check_eq("areset_busy", busy, 0);
    check_eq("areset_count", frame_count, 0);
    exp_count = 0;
    @(posedge clk); #1 reset_n = 1'b1;
    exp_q.delete();
    bit_idx = 0;
    d0 = done_cnt;
    repeat (3) pulse_rise(3);
    @(negedge clk);
    check_eq("areset_idle_state", dbg_state, IDLE);
    check_eq("areset_idle_done", done_cnt - d0, 0);

    // 256 complete frames wrap the counter back to zero.
    d0 = done_cnt;
    for (int i = 0; i < 256; i++)
      run_frame(NB'($urandom), NB'($urandom), FL, HMIN);
    check_eq("wrap_done_total", done_cnt - d0, 256);
    check_eq("wrap_count_zero", frame_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/joy_db15_resp.md
Name: joy_db15_resp

Overview:
- Peripheral-side responder for the serial DB15 joystick link: the transmitter that the joystick reader clocks.
- Captures two players' parallel button words when the reader asserts LOAD, then shifts them out one bit per rising edge of the reader's CLK, active-low, like a 74HC165 chain.
- Used in the bench-top adapter model and the loopback self-test path, with its pins driven across the user port.

Parameters:
- NBITS, 16, bits per player word; frame length is 2*NBITS.
- TIMEOUT, 4096, clk cycles without a joy_clk edge before an in-progress frame is abandoned.
- FILT_LEN, 3, stable-sample count for the optional input filter.

Ports:
- clk  in  1  responder clock; at least 4x the joy_clk toggle rate.
- reset_n  in  1  asynchronous, active-low reset.
- joy_clk  in  1  shift clock from the reader; asynchronous to clk.
- joy_load  in  1  parallel-load strobe from the reader, active low; asynchronous.
- joystick1  in  NBITS  player 1 buttons, 1 = pressed; bit 0 = R, 1 = L, 2 = D, 3 = U, upper bits are buttons.
- joystick2  in  NBITS  player 2 buttons, same layout.
- joy_data  out  1  serial data to the reader, active low (0 = pressed).
- frame_done  out  1  one-clk pulse when bit 2*NBITS-1 has been shifted past.
- frame_count  out  8  completed frames, wraps 255 -> 0.
- timeout  out  1  one-clk pulse when a frame is abandoned.
- busy  out  1  high in LOADED or SHIFT.

Behaviour:
- Reset: joy_data = 1, frame_done = 0, frame_count = 0, timeout = 0, busy = 0, shift register all 1s, state IDLE.
- Synchronisation: joy_clk and joy_load each pass through 2 FFs before use.
- Edge detection: a third register stage gives rise/fall.
- Latency: joy_data changes exactly 3 clk cycles after a joy_clk rising edge at the pin.
- Shift register width is 2*NBITS. The load value is the bitwise NOT of {joystick2, joystick1}.
- Bit order: joy_data presents joystick1[0] first; after joystick1[NBITS-1] comes joystick2[0].
- Serial-in is 1, so bits beyond the frame read as released (1).
- States:
  - IDLE: joy_load sync low -> load register, bit_cnt = 0, go to LOADED, joy_data = first bit.
  - LOADED: while load is held low, reload every cycle (transparent). When load goes high, go to SHIFT.
  - SHIFT:
    - On each joy_clk rise: shift one place and increment bit_cnt.
    - When bit_cnt reaches 2*NBITS-1 and a rise occurs: pulse frame_done, increment frame_count, go to DONE.
    - joy_load low in SHIFT -> reload, bit_cnt = 0, go to LOADED. This restart is not a timeout.
  - DONE: joy_data = 1. joy_load low -> LOADED.
- Watchdog:
  - Counts clk cycles in LOADED (after load release) and in SHIFT. It resets on every joy_clk rise.
  - If it reaches TIMEOUT: pulse timeout, joy_data = 1, go to IDLE; frame_count unchanged.
- Simultaneous joy_load fall and joy_clk rise in the same synchronised cycle: load wins and the shift is ignored.
- Parallel inputs are sampled only on load. Changes mid-frame do not affect the bits being shifted.
- An asynchronous reset mid-frame forces the reset values immediately; the next frame needs a fresh load.

Optional Feature:
- Macro JOY_DB15_RESP_FILTER_EN.
- When defined: the synchronised joy_clk and joy_load must hold the same level for FILT_LEN consecutive clk cycles before an edge is recognised. Pulses shorter than FILT_LEN are rejected, and latency becomes 3+FILT_LEN-1 cycles.
- When undefined: no filter, with the 3-cycle latency above.

Decomposition:
- Package joy_db15_pkg holds:
  - typedef state_t: IDLE, LOADED, SHIFT, DONE;
  - localparam DB15_BITS_PER_PLAYER = 16;
  - bit-index constants for the R, L, D, U positions.
- One natural sub-module, joy_sync_edge: a 2-FF synchroniser plus edge detector, with the optional filter. It is instanced twice, once for joy_clk and once for joy_load.

Test Plan:
- Basic frame:
  - Stimulus: joystick1 = 16'h0011, joystick2 = 16'h8002; load pulse, then 32 clk rises at clk/8.
  - Response: sampled serial stream 0,1,1,1,0,1...; bit 17 = 0, bit 31 = 0, all other bits 1; frame_done pulses once; frame_count = 1.
- Over-clocking: 40 rises after load -> bits 32..39 all read 1; a single frame_done.
- Timeout: load, 5 rises, then idle for 4096 cycles -> timeout pulses at cycle 4096, joy_data = 1, frame_count unchanged.
- Restart: load again after 10 rises -> stream restarts at joystick1[0]; no timeout or frame_done from the aborted frame.
- Coincident edges: joy_load fall and joy_clk rise in the same cycle -> register is reloaded, bit_cnt = 0, and the first bit is unchanged.
- Async reset: reset_n low mid-SHIFT -> joy_data = 1, busy = 0, frame_count = 0 within the same cycle.
- Wrap: 256 full frames -> frame_count returns to 0.
- Filter (macro defined): a 2-cycle joy_clk glitch is ignored; a 3-cycle pulse shifts one bit.
